// File: rtl/float_accumulator_e4m3.sv
// rtl/float_accumulator_e4m3.sv - sequential E4M3 accumulator (align/add/normalize per element).
// Optional sticky overflow/underflow flags enabled with FLOAT_ACC_FLAGS_EN.
module float_accumulator_e4m3 #(
    parameter int GUARD = 3,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_valid,
    input  logic             out_ready
`ifdef FLOAT_ACC_FLAGS_EN
    ,
    output logic             out_ovf,
    output logic             out_unf
`endif
);
    // Significand layout: carry | hidden | 3 mantissa | GUARD guard bits.
    localparam int SW = 5 + GUARD;
    localparam logic [3:0] FW4 = 4'(4 + GUARD);
    localparam logic [SW-1:0] SIG_MAX = {2'b01, 3'b111, {GUARD{1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

    state_t          state, state_nxt, state_fin;
    logic            acc_sign, acc_sign_nxt;
    logic [3:0]      acc_exp, acc_exp_nxt;
    logic [SW-1:0]   acc_sig, acc_sig_nxt;
    logic            op_sign, op_sign_nxt;
    logic [3:0]      op_exp, op_exp_nxt;
    logic [SW-1:0]   op_sig, op_sig_nxt;
    logic            last_q, last_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [3:0]      exp_diff;
    logic            sum_sign;
    logic [SW-1:0]   sum_mag;
`ifdef FLOAT_ACC_FLAGS_EN
    logic            ovf_q, ovf_nxt, unf_q, unf_nxt;
    assign out_ovf = ovf_q;
    assign out_unf = unf_q;
`endif

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign exp_diff  = (acc_exp >= op_exp) ? (acc_exp - op_exp) : (op_exp - acc_exp);
    assign state_fin = last_q ? S_DONE : S_IDLE;

    // Sign-magnitude add; both inputs have a clear carry bit, so no overflow.
    always_comb begin
        sum_sign = acc_sign;
        sum_mag  = acc_sig + op_sig;
        if (acc_sign != op_sign) begin
            if (acc_sig >= op_sig) begin
                sum_mag = acc_sig - op_sig;
            end else begin
                sum_mag  = op_sig - acc_sig;
                sum_sign = op_sign;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        acc_sign_nxt = acc_sign;
        acc_exp_nxt  = acc_exp;
        acc_sig_nxt  = acc_sig;
        op_sign_nxt  = op_sign;
        op_exp_nxt   = op_exp;
        op_sig_nxt   = op_sig;
        last_nxt     = last_q;
        count_nxt    = count;
`ifdef FLOAT_ACC_FLAGS_EN
        ovf_nxt      = ovf_q;
        unf_nxt      = unf_q;
`endif
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    op_sign_nxt = in_data[7];
                    op_exp_nxt  = in_data[6:3];
                    op_sig_nxt  = (in_data[6:3] == 4'd0) ? '0
                                : {2'b01, in_data[2:0], {GUARD{1'b0}}};
                    last_nxt    = in_last;
                    if (count != '1) count_nxt = count + 1'b1;
                    state_nxt   = S_ALIGN;
                end
            end
            S_ALIGN: begin
                // A zero accumulator has exp 0 and significand 0, so it aligns away naturally.
                if (acc_exp >= op_exp) begin
                    op_sig_nxt = (exp_diff >= FW4) ? '0 : (op_sig >> exp_diff);
                end else begin
                    acc_sig_nxt = (exp_diff >= FW4) ? '0 : (acc_sig >> exp_diff);
                    acc_exp_nxt = op_exp;
                end
                state_nxt = S_ADD;
            end
            S_ADD: begin
                if (sum_mag == '0) begin
                    acc_sign_nxt = 1'b0;
                    acc_exp_nxt  = 4'd0;
                    acc_sig_nxt  = '0;
                    state_nxt    = state_fin;
                end else begin
                    acc_sign_nxt = sum_sign;
                    acc_sig_nxt  = sum_mag;
                    state_nxt    = S_NORM;
                end
            end
            S_NORM: begin
                if (acc_sig[SW-1]) begin
                    if (acc_exp == 4'hF) begin
                        acc_sig_nxt = SIG_MAX;
`ifdef FLOAT_ACC_FLAGS_EN
                        ovf_nxt     = 1'b1;
`endif
                    end else begin
                        acc_sig_nxt = acc_sig >> 1;
                        acc_exp_nxt = acc_exp + 4'd1;
                    end
                    state_nxt = state_fin;
                end else if (!acc_sig[SW-2]) begin
                    if (acc_exp == 4'd1) begin
                        acc_sign_nxt = 1'b0;
                        acc_exp_nxt  = 4'd0;
                        acc_sig_nxt  = '0;
`ifdef FLOAT_ACC_FLAGS_EN
                        unf_nxt      = 1'b1;
`endif
                        state_nxt    = state_fin;
                    end else begin
                        acc_sig_nxt = acc_sig << 1;
                        acc_exp_nxt = acc_exp - 4'd1;
                    end
                end else begin
                    state_nxt = state_fin;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    acc_sign_nxt = 1'b0;
                    acc_exp_nxt  = 4'd0;
                    acc_sig_nxt  = '0;
                    count_nxt    = '0;
`ifdef FLOAT_ACC_FLAGS_EN
                    ovf_nxt      = 1'b0;
                    unf_nxt      = 1'b0;
`endif
                    state_nxt    = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            acc_sign  <= 1'b0;
            acc_exp   <= 4'd0;
            acc_sig   <= '0;
            op_sign   <= 1'b0;
            op_exp    <= 4'd0;
            op_sig    <= '0;
            last_q    <= 1'b0;
            count     <= '0;
            out_data  <= 8'h00;
            out_count <= '0;
`ifdef FLOAT_ACC_FLAGS_EN
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            acc_sign <= acc_sign_nxt;
            acc_exp  <= acc_exp_nxt;
            acc_sig  <= acc_sig_nxt;
            op_sign  <= op_sign_nxt;
            op_exp   <= op_exp_nxt;
            op_sig   <= op_sig_nxt;
            last_q   <= last_nxt;
            count    <= count_nxt;
`ifdef FLOAT_ACC_FLAGS_EN
            ovf_q    <= ovf_nxt;
            unf_q    <= unf_nxt;
`endif
            if (state_nxt == S_DONE && state != S_DONE) begin
                out_data  <= {acc_sign_nxt, acc_exp_nxt, acc_sig_nxt[SW-3 -: 3]};
                out_count <= count_nxt;
            end
        end
    end
endmodule
